// File: rtl/objective_if.sv
// Stream bundle between a neuron and its training objective.
//   result : neuron result (8b) into the objective
//   target : training target (8b) into the objective
//   error  : signed error (16b) back to the neuron
//   output : inference result (8b) forwarded downstream
// master = environment side, slave = objective side.
interface objective_if;
  logic        result_valid;
  logic [7:0]  result_data;
  logic        result_ready;
  logic        target_valid;
  logic [7:0]  target_data;
  logic        target_ready;
  logic        error_valid;
  logic [15:0] error_data;
  logic        error_ready;
  logic        output_valid;
  logic [7:0]  output_data;
  logic        output_ready;

  modport master (
    output result_valid, result_data, target_valid, target_data,
           error_ready, output_ready,
    input  result_ready, target_ready, error_valid, error_data,
           output_valid, output_data
  );

  modport slave (
    input  result_valid, result_data, target_valid, target_data,
           error_ready, output_ready,
    output result_ready, target_ready, error_valid, error_data,
           output_valid, output_data
  );
endinterface

// File: rtl/objective.sv
// Training objective: pairs a neuron result with a target and returns the
// signed, scaled difference as an error, or (inference) forwards the result.
// Ports:
//   clock, reset   rising-edge clock, async active-low reset
//   train          1 = pair result with target, 0 = forward result
//   clear          synchronous zeroing of both counters
//   bus            result/target in, error/output out (objective_if.slave)
//   sample_count   completed training pairs (saturating)
//   mistake_count  training pairs with target != result (saturating)
module objective #(
  parameter int SHIFT = 0,
  parameter int CW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          train,
  input  logic          clear,
  objective_if.slave    bus,
  output logic [CW-1:0] sample_count,
  output logic [CW-1:0] mistake_count
);

  localparam logic [2:0] EMPTY       = 3'd0;
  localparam logic [2:0] HAVE_RESULT = 3'd1;
  localparam logic [2:0] HAVE_TARGET = 3'd2;
  localparam logic [2:0] SEND_ERROR  = 3'd3;
  localparam logic [2:0] SEND_OUTPUT = 3'd4;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [2:0]  state, state_nxt;
  logic [7:0]  res_q, tgt_q;
  logic [15:0] err_q, err_nxt;
  logic        r_acc, t_acc, pair_go;
  logic [7:0]  pair_res, pair_tgt;
  logic [8:0]  diff;

  // Readies come only from state (and train), never from a valid, and are
  // forced low while reset is held.
  assign bus.result_ready = reset && (state == EMPTY || state == HAVE_TARGET);
  assign bus.target_ready = reset && (state == HAVE_RESULT ||
                                      (state == EMPTY && train));

  assign r_acc = bus.result_valid && bus.result_ready;
  assign t_acc = bus.target_valid && bus.target_ready;

  assign bus.error_valid  = (state == SEND_ERROR);
  assign bus.error_data   = err_q;
  assign bus.output_valid = (state == SEND_OUTPUT);
  assign bus.output_data  = res_q;

  // pair_res/pair_tgt select the live bus value for whichever half of the
  // pair arrives on the completing cycle, and the held copy otherwise.
  always_comb begin
    state_nxt = state;
    pair_go   = 1'b0;
    pair_res  = res_q;
    pair_tgt  = tgt_q;
    case (state)
      EMPTY: begin
        if (r_acc && t_acc) begin
          state_nxt = SEND_ERROR;
          pair_go   = 1'b1;
          pair_res  = bus.result_data;
          pair_tgt  = bus.target_data;
        end else if (r_acc) begin
          state_nxt = train ? HAVE_RESULT : SEND_OUTPUT;
        end else if (t_acc) begin
          state_nxt = HAVE_TARGET;
        end
      end
      HAVE_RESULT: begin
        if (t_acc) begin
          state_nxt = SEND_ERROR;
          pair_go   = 1'b1;
          pair_tgt  = bus.target_data;
        end
      end
      HAVE_TARGET: begin
        if (r_acc) begin
          state_nxt = SEND_ERROR;
          pair_go   = 1'b1;
          pair_res  = bus.result_data;
        end
      end
      SEND_ERROR:  if (bus.error_ready)  state_nxt = EMPTY;
      SEND_OUTPUT: if (bus.output_ready) state_nxt = EMPTY;
      default:     state_nxt = EMPTY;
    endcase
  end

  // 9-bit signed difference of zero-extended operands, sign-extended, scaled.
  assign diff    = {1'b0, pair_tgt} - {1'b0, pair_res};
  assign err_nxt = {{7{diff[8]}}, diff} << SHIFT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      res_q <= '0;
      tgt_q <= '0;
      err_q <= '0;
    end else begin
      state <= state_nxt;
      if (r_acc)   res_q <= bus.result_data;
      if (t_acc)   tgt_q <= bus.target_data;
      if (pair_go) err_q <= err_nxt;
    end
  end

  // clear wins over an increment on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_count  <= '0;
      mistake_count <= '0;
    end else if (clear) begin
      sample_count  <= '0;
      mistake_count <= '0;
    end else if (pair_go) begin
      if (sample_count != CNT_MAX) sample_count <= sample_count + CW'(1);
      if (pair_tgt != pair_res && mistake_count != CNT_MAX)
        mistake_count <= mistake_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_objective.sv
// Bench for objective: two instances (SHIFT=0/CW=16 and SHIFT=4/CW=4) share
// one stimulus stream and are compared against a behavioural model.
module tb_objective;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       train = 0, clear = 0;
  logic       r_valid = 0, t_valid = 0, e_ready = 0, o_ready = 0;
  logic [7:0] r_data = 0, t_data = 0;
  logic [15:0] samp0, mis0;
  logic [3:0]  samp1, mis1;

  objective_if if0();
  objective_if if1();

  assign if0.result_valid = r_valid;  assign if1.result_valid = r_valid;
  assign if0.result_data  = r_data;   assign if1.result_data  = r_data;
  assign if0.target_valid = t_valid;  assign if1.target_valid = t_valid;
  assign if0.target_data  = t_data;   assign if1.target_data  = t_data;
  assign if0.error_ready  = e_ready;  assign if1.error_ready  = e_ready;
  assign if0.output_ready = o_ready;  assign if1.output_ready = o_ready;

  objective #(.SHIFT(0), .CW(16)) dut0 (
    .clock(clock), .reset(reset), .train(train), .clear(clear), .bus(if0),
    .sample_count(samp0), .mistake_count(mis0));
  objective #(.SHIFT(4), .CW(4)) dut1 (
    .clock(clock), .reset(reset), .train(train), .clear(clear), .bus(if1),
    .sample_count(samp1), .mistake_count(mis1));

  // Behavioural model: what is held, what is pending, and the counts.
  bit          m_res_v, m_tgt_v, m_err_v, m_out_v;
  logic [7:0]  m_res, m_tgt, m_out;
  logic [15:0] m_err0, m_err1;
  int          m_s0, m_m0, m_s1, m_m1;
  int          nvec = 0, nerr = 0;

  function automatic bit exp_rr();
    return reset && !m_err_v && !m_out_v && !m_res_v;
  endfunction
  function automatic bit exp_tr();
    return reset && !m_err_v && !m_out_v && !m_tgt_v && (m_res_v || train);
  endfunction

  task automatic model_reset();
    m_res_v = 0; m_tgt_v = 0; m_err_v = 0; m_out_v = 0;
    m_res = 0; m_tgt = 0; m_out = 0; m_err0 = 0; m_err1 = 0;
    m_s0 = 0; m_m0 = 0; m_s1 = 0; m_m1 = 0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge and
  // drop any valid that was accepted.
  task automatic tick();
    bit racc, tacc;
    int d;
    racc = r_valid && exp_rr();
    tacc = t_valid && exp_tr();
    @(posedge clock);
    if (m_err_v && e_ready) m_err_v = 0;
    if (m_out_v && o_ready) m_out_v = 0;
    if (racc) begin m_res_v = 1; m_res = r_data; end
    if (tacc) begin m_tgt_v = 1; m_tgt = t_data; end
    if (m_res_v && m_tgt_v) begin
      d = int'(m_tgt) - int'(m_res);
      m_err0 = 16'(d);
      m_err1 = 16'(d * 16);
      m_err_v = 1;
      m_s0 = (m_s0 < 65535) ? m_s0 + 1 : m_s0;
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : m_s1;
      if (m_tgt != m_res) begin
        m_m0 = (m_m0 < 65535) ? m_m0 + 1 : m_m0;
        m_m1 = (m_m1 < 15) ? m_m1 + 1 : m_m1;
      end
      m_res_v = 0; m_tgt_v = 0;
    end else if (racc && !train) begin
      m_out_v = 1; m_out = m_res; m_res_v = 0;
    end
    if (clear) begin m_s0 = 0; m_m0 = 0; m_s1 = 0; m_m1 = 0; end
    #1;
    if (racc) r_valid = 0;
    if (tacc) t_valid = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clock);
    nvec++;
    if ({if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready} !== 4'b0) begin
      nerr++; $display("FAIL reset_ready got %b want 0000",
        {if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready});
    end
    nvec++;
    if ({if0.error_valid, if0.output_valid, if0.error_data, if0.output_data,
         samp0, mis0, samp1, mis1} !== 50'd0) begin
      nerr++; $display("FAIL reset_regs got ev=%b ov=%b ed=%h od=%h s=%0d m=%0d want zeros",
        if0.error_valid, if0.output_valid, if0.error_data, if0.output_data, samp0, mis0);
    end
    reset = 1;
    #1;
    nvec++;
    if ({if0.result_ready, if0.target_ready} !== 2'b10) begin
      nerr++; $display("FAIL post_reset_ready got %b want 10", {if0.result_ready, if0.target_ready});
    end
  endtask

  task automatic test_same_cycle();
    train = 1; r_valid = 1; r_data = 8'h40; t_valid = 1; t_data = 8'hC0; e_ready = 0;
    #1;
    nvec++;
    if ({if0.result_ready, if0.target_ready} !== 2'b11) begin
      nerr++; $display("FAIL same_ready got %b want 11", {if0.result_ready, if0.target_ready});
    end
    tick();
    nvec++;
    if ({if0.error_valid, if0.error_data, if1.error_data, samp0, mis0} !== {1'b1, 16'h0080, 16'h0800, 16'd1, 16'd1}) begin
      nerr++; $display("FAIL same_err got ev=%b e0=%h e1=%h s=%0d m=%0d want 1 0080 0800 1 1",
        if0.error_valid, if0.error_data, if1.error_data, samp0, mis0);
    end
    e_ready = 1;
    tick();
    nvec++;
    if (if0.error_valid !== 1'b0) begin
      nerr++; $display("FAIL same_drain got %b want 0", if0.error_valid);
    end
  endtask

  task automatic test_target_first();
    e_ready = 0; o_ready = 1;
    train = 1; t_valid = 1; t_data = 8'h10;
    tick();
    train = 0; r_valid = 1; r_data = 8'h10;
    #1;
    nvec++;
    if ({if0.result_ready, if0.target_ready} !== 2'b10) begin
      nerr++; $display("FAIL tfirst_ready got %b want 10", {if0.result_ready, if0.target_ready});
    end
    tick();
    nvec++;
    if ({if0.error_valid, if0.output_valid, if0.error_data, if1.error_data} !== {2'b10, 32'h0}) begin
      nerr++; $display("FAIL tfirst_err got ev=%b ov=%b e0=%h e1=%h want 1 0 0000 0000",
        if0.error_valid, if0.output_valid, if0.error_data, if1.error_data);
    end
    nvec++;
    if ({samp0, mis0} !== {16'd2, 16'd1}) begin
      nerr++; $display("FAIL tfirst_cnt got s=%0d m=%0d want 2 1", samp0, mis0);
    end
    e_ready = 1;
    tick();
  endtask

  task automatic test_stall();
    train = 1; r_valid = 1; r_data = 8'hFF; t_valid = 1; t_data = 8'h00; e_ready = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if ({if0.error_valid, if1.error_valid, if0.error_data, if1.error_data} !== {2'b11, 16'hFF01, 16'hF010}) begin
        nerr++; $display("FAIL stall_err cyc %0d got %b %b %h %h want 1 1 ff01 f010", k,
          if0.error_valid, if1.error_valid, if0.error_data, if1.error_data);
      end
      nvec++;
      if ({if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready} !== 4'b0) begin
        nerr++; $display("FAIL stall_ready cyc %0d got %b want 0000", k,
          {if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready});
      end
      tick();
    end
    e_ready = 1;
    tick();
  endtask

  task automatic test_inference();
    int s0, m0;
    s0 = m_s0; m0 = m_m0;
    train = 0; r_valid = 1; r_data = 8'h7A; o_ready = 0;
    #1;
    nvec++;
    if (if0.target_ready !== 1'b0) begin
      nerr++; $display("FAIL inf_tready got %b want 0", if0.target_ready);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if ({if0.output_valid, if0.output_data, if1.output_data, if0.target_ready, if0.error_valid} !== {1'b1, 8'h7A, 8'h7A, 2'b00}) begin
        nerr++; $display("FAIL inf_out cyc %0d got ov=%b od=%h tr=%b ev=%b want 1 7a 0 0", k,
          if0.output_valid, if0.output_data, if0.target_ready, if0.error_valid);
      end
      tick();
    end
    o_ready = 1;
    tick();
    nvec++;
    if ({if0.output_valid, samp0, mis0} !== {1'b0, 16'(s0), 16'(m0)}) begin
      nerr++; $display("FAIL inf_cnt got ov=%b s=%0d m=%0d want 0 %0d %0d", if0.output_valid, samp0, mis0, s0, m0);
    end
  endtask

  task automatic test_saturate();
    train = 1; e_ready = 1;
    for (int k = 0; k < 20; k++) begin
      r_data = 8'($urandom); t_data = ~r_data; r_valid = 1; t_valid = 1;
      tick(); tick();
    end
    nvec++;
    if ({samp1, mis1} !== 8'hFF) begin
      nerr++; $display("FAIL sat_cw4 got s=%0d m=%0d want 15 15", samp1, mis1);
    end
    nvec++;
    if ({samp0, mis0} !== {16'(m_s0), 16'(m_m0)}) begin
      nerr++; $display("FAIL sat_cw16 got s=%0d m=%0d want %0d %0d", samp0, mis0, m_s0, m_m0);
    end
    r_data = 8'h01; t_data = 8'h02; r_valid = 1; t_valid = 1; clear = 1;
    tick();
    clear = 0;
    nvec++;
    if ({if0.error_valid, samp0, mis0, samp1, mis1} !== 41'h100_0000_0000) begin
      nerr++; $display("FAIL clear_pri got ev=%b s0=%0d m0=%0d s1=%0d m1=%0d want 1 0 0 0 0",
        if0.error_valid, samp0, mis0, samp1, mis1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    train = 1; e_ready = 1; o_ready = 1; r_valid = 1; r_data = 8'h33;
    tick();
    #2;
    reset = 0;
    model_reset();
    t_valid = 1; t_data = 8'h44;
    #1;
    nvec++;
    if ({if0.result_ready, if0.target_ready, if0.error_valid, if0.output_valid} !== 4'b0) begin
      nerr++; $display("FAIL rmid_in_reset got %b want 0000",
        {if0.result_ready, if0.target_ready, if0.error_valid, if0.output_valid});
    end
    repeat (2) @(posedge clock);
    t_valid = 0;
    @(negedge clock);
    reset = 1;
    #1;
    nvec++;
    if ({if0.result_ready, if0.target_ready, if0.error_valid, if0.output_valid, samp0} !== {4'b1100, 16'd0}) begin
      nerr++; $display("FAIL rmid_after got rr=%b tr=%b ev=%b ov=%b s=%0d want 1 1 0 0 0",
        if0.result_ready, if0.target_ready, if0.error_valid, if0.output_valid, samp0);
    end
    e_ready = 0;
    r_valid = 1; r_data = 8'h12; t_valid = 1; t_data = 8'h34;
    tick();
    nvec++;
    if ({if0.error_valid, if0.error_data, if1.error_data, samp0, mis0} !== {1'b1, 16'h0022, 16'h0220, 16'd1, 16'd1}) begin
      nerr++; $display("FAIL rmid_pair got ev=%b e0=%h e1=%h s=%0d m=%0d want 1 0022 0220 1 1",
        if0.error_valid, if0.error_data, if1.error_data, samp0, mis0);
    end
    e_ready = 1;
    tick();
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      if (!r_valid && $urandom_range(0, 2) != 0) begin
        r_valid = 1;
        r_data  = ($urandom_range(0, 3) == 0) ? t_data : 8'($urandom);
      end
      if (!t_valid && $urandom_range(0, 2) != 0) begin
        t_valid = 1;
        t_data  = ($urandom_range(0, 3) == 0) ? r_data : 8'($urandom);
      end
      train   = 1'($urandom_range(0, 1));
      clear   = ($urandom_range(0, 15) == 0);
      e_ready = 1'($urandom_range(0, 1));
      o_ready = 1'($urandom_range(0, 1));
      #1;
      nvec++;
      if ({if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready} !== {2{exp_rr(), exp_tr()}}) begin
        nerr++; $display("FAIL rnd_ready cyc %0d got %b want %b", i,
          {if0.result_ready, if0.target_ready, if1.result_ready, if1.target_ready}, {2{exp_rr(), exp_tr()}});
      end
      tick();
      nvec++;
      if ({if0.error_valid, if0.output_valid, if1.error_valid, if1.output_valid} !== {2{m_err_v, m_out_v}}) begin
        nerr++; $display("FAIL rnd_valid cyc %0d got %b want %b", i,
          {if0.error_valid, if0.output_valid, if1.error_valid, if1.output_valid}, {2{m_err_v, m_out_v}});
      end
      if (m_err_v) begin
        nvec++;
        if ({if0.error_data, if1.error_data} !== {m_err0, m_err1}) begin
          nerr++; $display("FAIL rnd_err cyc %0d got %h %h want %h %h", i,
            if0.error_data, if1.error_data, m_err0, m_err1);
        end
      end
      if (m_out_v) begin
        nvec++;
        if ({if0.output_data, if1.output_data} !== {2{m_out}}) begin
          nerr++; $display("FAIL rnd_out cyc %0d got %h %h want %h", i, if0.output_data, if1.output_data, m_out);
        end
      end
      nvec++;
      if ({samp0, mis0, samp1, mis1} !== {16'(m_s0), 16'(m_m0), 4'(m_s1), 4'(m_m1)}) begin
        nerr++; $display("FAIL rnd_cnt cyc %0d got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
          samp0, mis0, samp1, mis1, m_s0, m_m0, m_s1, m_m1);
      end
    end
    clear = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_target_first();
    test_stall();
    test_inference();
    test_saturate();
    test_reset_mid();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/objective.md
OBJECTIVE -- requirements
Module: objective

Interface
REQ-001 Parameter SHIFT, default 0, range 0..7: left shift applied to the raw error difference.
REQ-002 Parameter CW, default 16: width of the sample and mistake counters.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 train  in  1  1 = pair result with target and emit error; 0 = forward result on output stream.
REQ-007 clear  in  1  synchronous zeroing of both counters.
REQ-008 result_valid/result_data/result_ready  in/in[8]/out: neuron result stream, consumed here.
REQ-009 target_valid/target_data/target_ready  in/in[8]/out: training target stream.
REQ-010 error_valid/error_data/error_ready  out/out[16]/in: signed error returned to the neuron.
REQ-011 output_valid/output_data/output_ready  out/out[8]/in: inference result forwarded downstream.
REQ-012 sample_count  out  CW: count of completed training pairs.
REQ-013 mistake_count  out  CW: count of training pairs with target_data != result_data.

Function
REQ-014 Transfer occurs on any stream SHALL be valid && ready at a rising clock edge; valid, once raised, SHALL hold with stable data until accepted.
REQ-015 FSM states SHALL be EMPTY, HAVE_RESULT, HAVE_TARGET, SEND_ERROR, SEND_OUTPUT.
REQ-016 result_ready SHALL be 1 only in EMPTY or HAVE_TARGET.
REQ-017 target_ready SHALL be 1 only in HAVE_RESULT, or in EMPTY while train = 1.
REQ-018 EMPTY: result and target accepted in the same cycle -> SEND_ERROR; result only, train = 1 -> HAVE_RESULT; result only, train = 0 -> SEND_OUTPUT; target only -> HAVE_TARGET.
REQ-019 HAVE_RESULT: target accepted -> SEND_ERROR; train is not re-sampled in this state.
REQ-020 HAVE_TARGET: result accepted -> SEND_ERROR, regardless of train.
REQ-021 SEND_ERROR: error_valid = 1; on error_ready -> EMPTY.
REQ-022 SEND_OUTPUT: output_valid = 1, output_data = held result; on output_ready -> EMPTY.
REQ-023 Latency: error_valid and output_valid SHALL assert on the cycle after the completing transfer; no combinational valid-to-ready paths.
REQ-024 error_data SHALL equal ({1'b0,target} - {1'b0,result}) as a 9-bit signed value, sign-extended to 16 bits, then shifted left by SHIFT; the value is registered and held while error_valid = 1.
REQ-025 On entry to SEND_ERROR, sample_count SHALL increment by 1, and mistake_count SHALL increment by 1 if target != result; both SHALL saturate at 2^CW-1.
REQ-026 clear SHALL zero both counters on the next edge and take priority over a same-cycle increment.
REQ-027 Inference passes (SEND_OUTPUT) SHALL NOT change either counter.

Reset
REQ-028 While reset = 0, the state SHALL be EMPTY and all valids, data registers and counters SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any held result or target with no output emitted.
REQ-030 result_ready and target_ready SHALL be 0 while reset = 0.

Verification
REQ-031 train = 1, result 0x40 and target 0xC0 accepted in the same cycle -> next cycle error_valid = 1, error_data = 0x0080, sample_count = 1, mistake_count = 1.
REQ-032 train = 1, target 0x10 first, then result 0x10 with train = 0 -> error_data = 0x0000, mistake_count unchanged, no output transfer.
REQ-033 SHIFT = 4, result 0xFF, target 0x00 -> error_data = 0xF010 (-255 << 4); error_ready held low 5 cycles -> error_valid and error_data stable, both ready signals = 0.
REQ-034 train = 0, result 0x7A -> output_valid next cycle with output_data = 0x7A; target_ready = 0 throughout; counters unchanged.
REQ-035 CW = 4, 20 mismatching pairs -> both counters saturate at 15; clear pulsed on a pair-completion cycle -> both counters read 0.
REQ-036 reset pulsed low while in HAVE_RESULT -> state EMPTY, no error or output emitted; next pair processes normally.
